// File: rtl/axis_mem_pkg.sv
// Shared types for the memory/AXI4-Stream transmit and receive blocks.
// M_AXIS_MEM_STRB_EN adds a per-beat byte-strobe field to the beat struct.
package axis_mem_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_ADDR_WIDTH = 5;
  localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam int BUF_DEPTH       = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } tx_state_t;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
`ifdef M_AXIS_MEM_STRB_EN
    logic [AXIS_STRB_WIDTH-1:0] strb;
`endif
    logic                       last;
  } beat_t;

endpackage

// File: rtl/axis_mem_prefetch_buf.sv
// Two-entry FIFO of stream beats that absorbs read data while the
// downstream sink stalls. Never pushed when full (the caller's credit prevents it).
module axis_mem_prefetch_buf
  import axis_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic       empty,
  output logic [1:0] occupancy
);

  beat_t      entries [BUF_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  assign head      = entries[rd_ptr];
  assign empty     = (count == 2'd0);
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_beat;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/m_axis_mem.sv
// Memory-to-AXI4-Stream transmitter: streams tx_len+1 words from tx_base as one packet.
// Build option M_AXIS_MEM_STRB_EN carries mem_read_be through to m_axis_tstrb.
module m_axis_mem
  import axis_mem_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int ADDR_WIDTH = AXIS_ADDR_WIDTH
) (
  input  logic                    m_axis_aclk,
  input  logic                    m_axis_aresetn,
  input  logic                    tx_start,
  input  logic [ADDR_WIDTH-1:0]   tx_base,
  input  logic [ADDR_WIDTH-1:0]   tx_len,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    mem_read_en,
  output logic [ADDR_WIDTH-1:0]   mem_read_address,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic [DATA_WIDTH/8-1:0] mem_read_be,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  tx_state_t             state;
  tx_state_t             next_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   reads_left;
  logic                  in_flight;
  logic                  in_flight_last;
  beat_t                 push_beat;
  beat_t                 buf_head;
  beat_t                 head;
  logic                  buf_empty;
  logic                  buf_push;
  logic                  buf_pop;
  logic                  beat_pop;
  logic [1:0]            occupancy;
  logic [2:0]            held_after_pop;

  assign push_beat.data = mem_read_data;
  assign push_beat.last = in_flight_last;
`ifdef M_AXIS_MEM_STRB_EN
  assign push_beat.strb = mem_read_be;
`endif

  // Read data arriving into an empty buffer is presented directly so the
  // first beat appears the cycle after its read, not two cycles later.
  assign m_axis_tvalid = !buf_empty || in_flight;
  assign head          = (buf_empty && in_flight) ? push_beat : buf_head;
  assign beat_pop      = m_axis_tvalid && m_axis_tready;
  assign buf_pop       = beat_pop && !buf_empty;
  assign buf_push      = in_flight && !(buf_empty && beat_pop);

  assign held_after_pop = 3'(occupancy) + 3'(in_flight) - 3'(beat_pop);
  assign mem_read_en    = (state == ST_RUN) && (reads_left != '0)
                          && (held_after_pop < 3'(BUF_DEPTH));

  assign mem_read_address = rd_addr;
  assign m_axis_tdata     = head.data;
  assign m_axis_tlast     = m_axis_tvalid && head.last;
  assign tx_busy          = (state == ST_RUN);
  assign tx_done          = (state == ST_DONE);

`ifdef M_AXIS_MEM_STRB_EN
  assign m_axis_tstrb = head.strb;
`else
  logic unused_be;
  assign unused_be    = ^mem_read_be;
  assign m_axis_tstrb = {STRB_WIDTH{m_axis_tvalid}};
`endif

  axis_mem_prefetch_buf u_buf (
    .clk       (m_axis_aclk),
    .rst_n     (m_axis_aresetn),
    .push      (buf_push),
    .push_beat (push_beat),
    .pop       (buf_pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state          <= ST_IDLE;
      rd_addr        <= '0;
      reads_left     <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      state          <= next_state;
      in_flight      <= mem_read_en;
      in_flight_last <= mem_read_en && (reads_left == (ADDR_WIDTH+1)'(1));
      if (state == ST_IDLE && tx_start) begin
        rd_addr    <= tx_base;
        reads_left <= (ADDR_WIDTH+1)'(tx_len) + (ADDR_WIDTH+1)'(1);
      end else if (mem_read_en) begin
        rd_addr    <= rd_addr + ADDR_WIDTH'(1);
        reads_left <= reads_left - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (tx_start) next_state = ST_RUN;
      ST_RUN:  if (beat_pop && head.last) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_axis_mem.sv
// Self-checking bench for m_axis_mem with a synchronous-read memory model.
// Expected strobes follow M_AXIS_MEM_STRB_EN when it is defined for the build.
module tb_m_axis_mem;

  logic        m_axis_aclk = 1'b0;
  logic        m_axis_aresetn = 1'b0;
  logic        tx_start = 1'b0;
  logic [4:0]  tx_base = '0;
  logic [4:0]  tx_len = '0;
  logic        tx_busy, tx_done, mem_read_en;
  logic [4:0]  mem_read_address;
  logic [31:0] mem_read_data = '0;
  logic [3:0]  mem_read_be = '0;
  logic        m_axis_tvalid, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [32];
  logic [3:0]  mem_be [32];

  logic [31:0] got_data [$];
  logic [3:0]  got_strb [$];
  logic        got_last [$];
  int          got_cyc [$];
  int          first_valid_cyc, done_cyc, done_count, credit_err, stable_err;
  logic        busy_at1, rden_at1, busy_at_done, aborted;

  m_axis_mem dut (
    .m_axis_aclk      (m_axis_aclk),
    .m_axis_aresetn   (m_axis_aresetn),
    .tx_start         (tx_start),
    .tx_base          (tx_base),
    .tx_len           (tx_len),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .mem_read_en      (mem_read_en),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .mem_read_be      (mem_read_be),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tstrb     (m_axis_tstrb),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready)
  );

  always #5 m_axis_aclk = ~m_axis_aclk;

  always @(posedge m_axis_aclk) begin
    if (mem_read_en) begin
      mem_read_data <= mem[mem_read_address];
      mem_read_be   <= mem_be[mem_read_address];
    end
  end

  function automatic logic [3:0] exp_strb(input int addr);
`ifdef M_AXIS_MEM_STRB_EN
    return mem_be[addr];
`else
    return 4'hF;
`endif
  endfunction

  // Launches one packet and records what the stream and control outputs did.
  task automatic applyStimulus(input int base, input int len, input int ready_pct,
                               input int restart_at, input int abort_after, input int max_cycles);
    int issued, popped;
    logic prev_stall;
    logic [31:0] pd;
    logic [3:0] ps;
    logic pl;
    got_data.delete(); got_strb.delete(); got_last.delete(); got_cyc.delete();
    first_valid_cyc = -1; done_cyc = -1; done_count = 0;
    credit_err = 0; stable_err = 0; aborted = 1'b0;
    busy_at1 = 1'b0; rden_at1 = 1'b0; busy_at_done = 1'b1;
    issued = 0; popped = 0; prev_stall = 1'b0; pd = '0; ps = '0; pl = 1'b0;
    @(posedge m_axis_aclk); #1;
    tx_start = 1'b1; tx_base = 5'(base); tx_len = 5'(len);
    @(posedge m_axis_aclk); #1;
    tx_start = 1'b0;
    for (int c = 1; c <= max_cycles; c++) begin
      m_axis_tready = ($urandom_range(99) < ready_pct);
      tx_start = (c == restart_at);
      if (c == restart_at) begin
        tx_base = 5'(base + 9);
        tx_len  = 5'(len + 5);
      end
      @(negedge m_axis_aclk);
      if (c == 1) begin
        busy_at1 = tx_busy;
        rden_at1 = mem_read_en;
      end
      if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = c;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tstrb !== ps || m_axis_tlast !== pl))
        stable_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; ps = m_axis_tstrb; pl = m_axis_tlast;
      if (mem_read_en) issued++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_data.push_back(m_axis_tdata);
        got_strb.push_back(m_axis_tstrb);
        got_last.push_back(m_axis_tlast);
        got_cyc.push_back(c);
        popped++;
      end
      if (issued - popped > 2) credit_err++;
      if (tx_done) begin
        done_count++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = tx_busy;
        end
      end
      if (abort_after > 0 && got_data.size() == abort_after) begin
        m_axis_aresetn = 1'b0;
        #1;
        aborted = 1'b1;
        tx_start = 1'b0;
        return;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(posedge m_axis_aclk); #1;
    end
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0h expected 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0h expected 0", tx_done); end
    checks++; if (mem_read_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rden: got %0h expected 0", mem_read_en); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid: got %0h expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast: got %0h expected 0", m_axis_tlast); end
    checks++; if (mem_read_address !== 5'd0) begin failures++; $display("[TB] FAIL reset_addr: got %0h expected 0", mem_read_address); end
    checks++; if (m_axis_tdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_tdata: got %0h expected 0", m_axis_tdata); end
    checks++; if (m_axis_tstrb !== 4'd0) begin failures++; $display("[TB] FAIL reset_tstrb: got %0h expected 0", m_axis_tstrb); end
  endtask

  task automatic test_basic();
    applyStimulus(3, 3, 100, 0, 0, 60);
    checks++; if (busy_at1 !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_e1: got %0h expected 1", busy_at1); end
    checks++; if (rden_at1 !== 1'b1) begin failures++; $display("[TB] FAIL basic_rden_e1: got %0h expected 1", rden_at1); end
    checks++; if (first_valid_cyc != 2) begin failures++; $display("[TB] FAIL basic_first_valid: got %0d expected 2", first_valid_cyc); end
    checks++; if (done_cyc != 6) begin failures++; $display("[TB] FAIL basic_done_cycle: got %0d expected 6", done_cyc); end
    checks++; if (busy_at_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_at_done: got %0h expected 0", busy_at_done); end
    checks++; if (got_data.size() != 4) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 4", got_data.size()); end
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== 32'h1003 + k || got_last[k] !== (k == 3) || got_cyc[k] != 2 + k) begin
        failures++;
        $display("[TB] FAIL basic_beat%0d: got data=%h last=%0d cyc=%0d expected data=%h last=%0d cyc=%0d",
                 k, got_data[k], got_last[k], got_cyc[k], 32'h1003 + k, (k == 3), 2 + k);
      end
    end
  endtask

  task automatic test_wrap();
    applyStimulus(30, 4, 100, 0, 0, 60);
    checks++; if (got_data.size() != 5) begin failures++; $display("[TB] FAIL wrap_count: got %0d expected 5", got_data.size()); end
    for (int k = 0; k < 5 && k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== 32'h1000 + ((30 + k) % 32)) begin
        failures++;
        $display("[TB] FAIL wrap_beat%0d: got %h expected %h", k, got_data[k], 32'h1000 + ((30 + k) % 32));
      end
    end
    checks++; if (done_count != 1) begin failures++; $display("[TB] FAIL wrap_done_count: got %0d expected 1", done_count); end
  endtask

  task automatic test_strb();
    mem_be[5] = 4'h3;
    applyStimulus(4, 3, 100, 0, 0, 60);
    checks++; if (got_strb.size() != 4) begin failures++; $display("[TB] FAIL strb_count: got %0d expected 4", got_strb.size()); end
    for (int k = 0; k < 4 && k < got_strb.size(); k++) begin
      checks++;
      if (got_strb[k] !== exp_strb(4 + k)) begin
        failures++;
        $display("[TB] FAIL strb_beat%0d: got %h expected %h", k, got_strb[k], exp_strb(4 + k));
      end
    end
    mem_be[5] = 4'hF;
  endtask

  task automatic test_start_ignored();
    applyStimulus(10, 7, 70, 3, 0, 100);
    checks++; if (done_count != 1) begin failures++; $display("[TB] FAIL restart_done_count: got %0d expected 1", done_count); end
    checks++; if (got_data.size() != 8) begin failures++; $display("[TB] FAIL restart_count: got %0d expected 8", got_data.size()); end
    for (int k = 0; k < 8 && k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== mem[(10 + k) % 32] || got_last[k] !== (k == 7)) begin
        failures++;
        $display("[TB] FAIL restart_beat%0d: got %h/%0d expected %h/%0d", k, got_data[k], got_last[k], mem[(10 + k) % 32], (k == 7));
      end
    end
  endtask

  task automatic test_backpressure(input int base, input int len, input int pct, input string tag);
    int errs;
    applyStimulus(base, len, pct, 0, 0, 800);
    errs = 0;
    checks++; if (got_data.size() != len + 1) begin failures++; $display("[TB] FAIL %s_count: got %0d expected %0d", tag, got_data.size(), len + 1); end
    for (int k = 0; k <= len && k < got_data.size(); k++) begin
      if (got_data[k] !== mem[(base + k) % 32] || got_strb[k] !== exp_strb((base + k) % 32) || got_last[k] !== (k == len))
        errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("[TB] FAIL %s_payload: got %0d bad beats expected 0", tag, errs); end
    checks++; if (stable_err != 0) begin failures++; $display("[TB] FAIL %s_stable: got %0d changes expected 0", tag, stable_err); end
    checks++; if (credit_err != 0) begin failures++; $display("[TB] FAIL %s_credit: got %0d overruns expected 0", tag, credit_err); end
    checks++; if (done_count != 1) begin failures++; $display("[TB] FAIL %s_done_count: got %0d expected 1", tag, done_count); end
  endtask

  task automatic test_reset_abort();
    int base;
    base = int'($urandom_range(31));
    applyStimulus(base, 7, 100, 0, 2, 60);
    checks++; if (aborted !== 1'b1) begin failures++; $display("[TB] FAIL abort_reached: got %0d expected 1", aborted); end
    test_reset();
    repeat (2) @(negedge m_axis_aclk);
    m_axis_aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge m_axis_aclk);
      checks++;
      if (tx_done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL abort_quiet%0d: got done=%0d valid=%0d expected 0/0", i, tx_done, m_axis_tvalid);
      end
    end
    test_backpressure(base, 7, 100, "abort_restart");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]    = 32'h1000 + i;
      mem_be[i] = 4'hF;
    end
    repeat (3) @(negedge m_axis_aclk);
    test_reset();
    m_axis_aresetn = 1'b1;
    @(negedge m_axis_aclk);
    test_basic();
    test_wrap();
    test_strb();
    test_start_ignored();
    for (int i = 0; i < 32; i++) begin
      mem[i]    = $urandom;
      mem_be[i] = 4'($urandom_range(15));
    end
    test_backpressure(int'($urandom_range(31)), 31, 50, "random_full");
    for (int r = 0; r < 3; r++) begin
      test_backpressure(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(100, 30)), "random_pkt");
    end
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
